// File: rtl/m16_pkg.sv
// Shared constants and types for the M16 orbit frame writer.
// Frame geometry, marker slot position and FSM state encoding.
package m16_pkg;

    localparam int M16_WORDS     = 2048;
    localparam int M16_AW        = 11;
    localparam int M16_MARK_SLOT = 16;
    localparam int M16_FRM_W     = 7;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } m16_state_e;

    // The serializer ORs marker bits into bit 11 of this slot, so it must arrive clean.
    function automatic logic [11:0] mark_clear(
        input logic [11:0] d,
        input logic [4:0]  slot
    );
        logic [11:0] r;
        r = d;
        if (slot == 5'(M16_MARK_SLOT))
            r[11] = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/m16_frame_writer_if.sv
// Sample stream in, frame RAM write port out, plus frame status.
// Slave modport is the writer; master modport is the environment driving it.
interface m16_frame_writer_if;
    import m16_pkg::*;

    logic                   iSwitch;
    logic [11:0]            iData;
    logic                   iVal;
    logic                   oReady;
    logic [M16_AW:0]        oWrAddr;
    logic [11:0]            oWrData;
    logic                   oWrEn;
    logic                   oFull;
    logic                   oUnderrun;
    logic                   oOverrun;
    logic [M16_AW:0]        oLastCnt;
    logic [M16_FRM_W-1:0]   oFrame;

    modport master (
        output iSwitch, iData, iVal,
        input  oReady, oWrAddr, oWrData, oWrEn,
        input  oFull, oUnderrun, oOverrun, oLastCnt, oFrame
    );

    modport slave (
        input  iSwitch, iData, iVal,
        output oReady, oWrAddr, oWrData, oWrEn,
        output oFull, oUnderrun, oOverrun, oLastCnt, oFrame
    );

endinterface

// File: rtl/m16_frame_writer.sv
// M16 frame writer: fills the ping-pong bank the serializer is not reading.
// One FILL/FULL FSM plus the word and frame counters.
module m16_frame_writer
    import m16_pkg::*;
(
    input  logic                 iClkOrb,
    input  logic                 reset,
    m16_frame_writer_if.slave    bus
);

    localparam int              AW    = M16_AW;
    localparam logic [AW:0]     WORDS = (AW+1)'(M16_WORDS);

    m16_state_e             state;
    m16_state_e             state_nxt;
    logic                   sw_prev;
    logic [AW:0]            wr_cnt;
    logic [AW:0]            cnt_nxt;
    logic                   tgl;
    logic                   ready;
    logic                   acc;
    logic [AW-1:0]          word;

    logic                   wr_en;
    logic [AW:0]            wr_addr;
    logic [11:0]            wr_data;
    logic                   underrun;
    logic                   overrun;
    logic [AW:0]            last_cnt;
    logic [M16_FRM_W-1:0]   frame;

    assign tgl   = bus.iSwitch ^ sw_prev;
    // Ready is held low while reset is asserted so every output reads 0.
    assign ready = reset & (tgl | (state == FILL));
    assign acc   = bus.iVal & ready;
    assign word  = tgl ? '0 : wr_cnt[AW-1:0];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = wr_cnt;
        if (tgl) begin
            state_nxt = FILL;
            cnt_nxt   = {{AW{1'b0}}, acc};
        end else if (acc) begin
            if (wr_cnt == WORDS - 1'b1)
                state_nxt = FULL;
            if (wr_cnt != WORDS)
                cnt_nxt = wr_cnt + 1'b1;
        end
    end

    always_ff @(posedge iClkOrb or negedge reset) begin
        if (!reset)
            state <= FILL;
        else
            state <= state_nxt;
    end

    always_ff @(posedge iClkOrb or negedge reset) begin
        if (!reset) begin
            sw_prev  <= 1'b0;
            wr_cnt   <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            underrun <= 1'b0;
            overrun  <= 1'b0;
            last_cnt <= '0;
            frame    <= '0;
        end else begin
            sw_prev  <= bus.iSwitch;
            wr_cnt   <= cnt_nxt;
            wr_en    <= acc;
            underrun <= tgl & (wr_cnt < WORDS);
            overrun  <= bus.iVal & ~ready;
            if (acc) begin
                wr_addr <= {~bus.iSwitch, word};
                wr_data <= mark_clear(bus.iData, word[4:0]);
            end
            if (tgl) begin
                last_cnt <= wr_cnt;
                frame    <= frame + 1'b1;
            end
        end
    end

    assign bus.oReady    = ready;
    assign bus.oFull     = (state == FULL);
    assign bus.oWrEn     = wr_en;
    assign bus.oWrAddr   = wr_addr;
    assign bus.oWrData   = wr_data;
    assign bus.oUnderrun = underrun;
    assign bus.oOverrun  = overrun;
    assign bus.oLastCnt  = last_cnt;
    assign bus.oFrame    = frame;

endmodule

// File: tb/tb_m16_frame_writer.sv
// Scoreboard bench for m16_frame_writer against a word-count frame model.
// Stimulus is driven on the falling edge; monitors sample off-edge.
module tb_m16_frame_writer;

    localparam int WORDS = 2048;

    logic clk;
    logic rst_n;

    m16_frame_writer_if bus();

    m16_frame_writer dut (
        .iClkOrb (clk),
        .reset   (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr_en;
        logic        ovr;
        logic        und;
        logic [11:0] last;
        logic [6:0]  frame;
        logic [11:0] addr;
        logic [11:0] data;
    } reg_exp_t;

    typedef struct {
        logic [11:0] addr;
        logic [11:0] data;
    } wr_t;

    typedef struct {
        logic ready;
        logic full;
    } comb_t;

    reg_exp_t reg_q[$];
    wr_t      wr_q[$];
    comb_t    comb_q[$];

    int n_chk = 0;
    int n_err = 0;

    int          m_cnt;
    int          m_frame;
    int          m_last;
    bit          m_sw_prev;
    logic [11:0] m_addr;
    logic [11:0] m_data;
    bit          sw;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_reg(input bit we, input bit ovr, input bit und);
        reg_exp_t e;
        e.wr_en = we;
        e.ovr   = ovr;
        e.und   = und;
        e.last  = 12'(m_last);
        e.frame = 7'(m_frame);
        e.addr  = m_addr;
        e.data  = m_data;
        reg_q.push_back(e);
    endtask

    task automatic rst_cycle();
        comb_t c;
        @(negedge clk);
        rst_n       = 1'b0;
        sw          = 1'b0;
        bus.iSwitch = 1'b0;
        bus.iVal    = 1'b0;
        bus.iData   = '0;
        m_cnt     = 0;
        m_frame   = 0;
        m_last    = 0;
        m_sw_prev = 1'b0;
        m_addr    = '0;
        m_data    = '0;
        c.ready = 1'b0;
        c.full  = 1'b0;
        comb_q.push_back(c);
        push_reg(1'b0, 1'b0, 1'b0);
    endtask

    task automatic step(input bit s, input bit val, input logic [11:0] d);
        comb_t c;
        wr_t   w;
        bit    tgl;
        bit    und;
        bit    acc;
        int    wd;
        @(negedge clk);
        rst_n       = 1'b1;
        bus.iSwitch = s;
        bus.iVal    = val;
        bus.iData   = d;
        tgl = (s != m_sw_prev);
        m_sw_prev = s;
        und = 1'b0;
        c.full = (m_cnt == WORDS);
        if (tgl) begin
            m_last  = m_cnt;
            und     = (m_cnt < WORDS);
            m_frame = (m_frame + 1) % 128;
            m_cnt   = 0;
        end
        c.ready = (m_cnt < WORDS);
        comb_q.push_back(c);
        acc = val && c.ready;
        if (acc) begin
            wd     = m_cnt;
            m_addr = 12'((s ? 0 : WORDS) + wd);
            m_data = (wd % 32 == 16) ? (d & 12'h7FF) : d;
            w.addr = m_addr;
            w.data = m_data;
            wr_q.push_back(w);
            m_cnt++;
        end
        push_reg(acc, val && !c.ready, und);
    endtask

    initial begin
        comb_t c;
        forever begin
            @(negedge clk);
            #1;
            if (comb_q.size() > 0) begin
                c = comb_q.pop_front();
                chk("ready", 32'(bus.oReady), 32'(c.ready));
                chk("full", 32'(bus.oFull), 32'(c.full));
            end
        end
    end

    initial begin
        reg_exp_t e;
        wr_t      w;
        forever begin
            @(posedge clk);
            #1;
            if (reg_q.size() > 0) begin
                e = reg_q.pop_front();
                chk("wr_en", 32'(bus.oWrEn), 32'(e.wr_en));
                if (bus.oWrEn === 1'b1) begin
                    if (wr_q.size() == 0) begin
                        chk("wr_q_nonempty", 32'd0, 32'd1);
                    end else begin
                        w = wr_q.pop_front();
                        chk("wr_addr", 32'(bus.oWrAddr), 32'(w.addr));
                        chk("wr_data", 32'(bus.oWrData), 32'(w.data));
                    end
                end else begin
                    chk("hold_addr", 32'(bus.oWrAddr), 32'(e.addr));
                    chk("hold_data", 32'(bus.oWrData), 32'(e.data));
                end
                chk("overrun", 32'(bus.oOverrun), 32'(e.ovr));
                chk("underrun", 32'(bus.oUnderrun), 32'(e.und));
                chk("last_cnt", 32'(bus.oLastCnt), 32'(e.last));
                chk("frame", 32'(bus.oFrame), 32'(e.frame));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        sw          = 1'b0;
        bus.iSwitch = 1'b0;
        bus.iVal    = 1'b0;
        bus.iData   = '0;
        repeat (3) rst_cycle();

        // full bank of all-ones, then overruns while full
        for (int i = 0; i < WORDS; i++)
            step(1'b0, 1'b1, 12'hFFF);
        repeat (5) step(1'b0, 1'b1, 12'($urandom));
        sw = 1'b1;
        step(sw, 1'b0, '0);
        step(sw, 1'b1, 12'($urandom));

        // short frame of 100 words
        while (m_cnt < 100)
            step(sw, 1'($urandom), 12'($urandom));
        sw = ~sw;
        step(sw, 1'b0, '0);
        repeat (4) step(sw, 1'($urandom), 12'($urandom));

        // toggle lands on the 2048th accept
        while (m_cnt < WORDS - 1)
            step(sw, $urandom_range(0, 3) != 0, 12'($urandom));
        sw = ~sw;
        step(sw, 1'b1, 12'($urandom));
        repeat (4) step(sw, 1'($urandom), 12'($urandom));

        // reset mid-frame at word 500
        while (m_cnt < 500)
            step(sw, 1'b1, 12'($urandom));
        rst_cycle();
        repeat (50) step(sw, 1'($urandom), 12'($urandom));

        // 130 toggles, some back to back
        for (int t = 0; t < 130; t++) begin
            sw = ~sw;
            step(sw, 1'($urandom), 12'($urandom));
            repeat ($urandom_range(0, 3)) step(sw, 1'($urandom), 12'($urandom));
        end
        chk("frame_wrap_model", 32'(m_frame), 32'd2);

        repeat (300) begin
            if ($urandom_range(0, 40) == 0)
                sw = ~sw;
            step(sw, 1'($urandom), 12'($urandom));
        end

        repeat (3) step(sw, 1'b0, '0);
        repeat (2) @(posedge clk);
        #2;
        chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
